// File: rtl/bus_pkg.sv
// Shared definitions for the tagged request/response bus between caches and memory.
package bus_pkg;

  localparam int unsigned TAG_WRITE_BIT = 12;
  localparam int unsigned TXN_ID_W      = 12;
  localparam int unsigned TAG_W         = TXN_ID_W + 1;
  localparam int unsigned BURST_BEATS   = 8;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [TXN_ID_W-1:0] txn_id_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ACK,
    WAIT,
    RESP,
    WDATA
  } resp_state_e;

  // Response tags echo the transaction id with the WRITE flag stripped.
  function automatic tag_t resp_tag(input tag_t t);
    tag_t r;
    r                = t;
    r[TAG_WRITE_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/bus_resp_mem.sv
// Single-port synchronous backing store: one read or one write per cycle,
// registered read data that holds its value between reads.
module bus_resp_mem #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: only reloads on a read, so the bus beat stays stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder: accepts line requests, returns or absorbs one line as a
// BURST_BEATS burst, and models a fixed DRAM latency before read data.
module bus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BURST_BEATS    = 8,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned LATENCY        = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);
  import bus_pkg::*;

  localparam int unsigned BYTE_OFF = $clog2(BUS_DATA_WIDTH / 8);
  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam int unsigned BW       = $clog2(BURST_BEATS);
  localparam int unsigned LW       = AW - BW;
  localparam int unsigned CW       = $clog2(LATENCY + 1);

  resp_state_e     state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  tag_t            tag_q, tag_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   lat_q, lat_d;
  logic            wack_q, wack_d;

  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic            last_beat;

  assign last_beat = (beat_q == BW'(BURST_BEATS - 1));

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      wack_q  <= wack_d;
    end
  end

  // Next-state logic and memory port control. The read for beat N+1 is issued in the
  // same cycle beat N is acked so the next beat appears without a bubble.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    tag_d    = tag_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    wack_d   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {line_q, beat_q};
    unique case (state_q)
      IDLE: begin
        if (bus_reqcyc) begin
          // Upper address bits beyond the store depth are dropped (silent wrap).
          line_d  = bus_req[BYTE_OFF + BW +: LW];
          tag_d   = bus_reqtag;
          beat_d  = '0;
          state_d = HDR_ACK;
        end
      end
      HDR_ACK: begin
        if (tag_q[TAG_WRITE_BIT]) begin
          state_d = WDATA;
        end else begin
          lat_d   = CW'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - CW'(1);
        if (lat_q == CW'(1)) begin
          mem_en  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus_respack) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d   = beat_q + BW'(1);
            mem_en   = 1'b1;
            mem_addr = {line_q, beat_q + BW'(1)};
          end
        end
      end
      WDATA: begin
        // A beat is written once, then acked next cycle; the still-asserted reqcyc
        // during the ack cycle is the same beat and must not be written again.
        if (wack_q) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (bus_reqcyc) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          wack_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bus_resp_mem #(
    .DATA_W (BUS_DATA_WIDTH),
    .ADDR_W (AW)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (bus_req),
    .rdata_o (bus_resp)
  );

  assign bus_reqack  = (state_q == HDR_ACK) || wack_q;
  assign bus_respcyc = (state_q == RESP);
  assign bus_resptag = resp_tag(tag_q);
  assign busy        = (state_q != IDLE);

endmodule
